// File: rtl/jk_driver.sv
// Drives a downstream JK flip-flop with {J,K} = op for cmd_len+1 cycles.
// It models the expected Q, then compares that model against the fed-back Q for one CHECK cycle.
module jk_driver #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             q_fb,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             err,
  output logic             exp_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_op;
  logic [LEN_W-1:0] r_cnt;
  logic             r_j;
  logic             r_k;
  logic             r_exp;
  logic             r_err;
  logic             w_accept;
  logic             w_last;
  logic             w_exp_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt == '0) begin
          w_last       = 1'b1;
          w_next_state = CHECK;
        end
      end
      CHECK:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Expected Q after one more clock of the downstream flip-flop under the latched op.
  always_comb begin
    w_exp_next = r_exp;
    case (r_op)
      2'b00:   w_exp_next = r_exp;
      2'b01:   w_exp_next = 1'b0;
      2'b10:   w_exp_next = 1'b1;
      default: w_exp_next = ~r_exp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= 2'b00;
      r_cnt <= '0;
      r_j   <= 1'b0;
      r_k   <= 1'b0;
      r_exp <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= cmd_op;
            r_cnt      <= cmd_len;
            r_exp      <= q_fb;
            r_err      <= 1'b0;
            {r_j, r_k} <= cmd_op;
          end
        end
        DRIVE: begin
          r_exp <= w_exp_next;
          if (w_last) {r_j, r_k} <= 2'b00;
          else        r_cnt      <= r_cnt - CNT_ONE;
        end
        CHECK: begin
          if (mismatch) r_err <= 1'b1;
        end
        default: begin
          {r_j, r_k} <= 2'b00;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE) & rst_n;
  assign busy      = (r_state == DRIVE) | (r_state == CHECK);
  assign done      = (r_state == CHECK);
  assign mismatch  = done & (q_fb != r_exp);
  assign J         = r_j;
  assign K         = r_k;
  assign err       = r_err;
  assign exp_q     = r_exp;

endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: it applies directed and random commands and checks every output, every cycle.
// The reference is a cycle-since-accept model with closed-form expected Q.
module tb_jk_driver;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             q_fb;
  logic             J;
  logic             K;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic             err;
  logic             exp_q;

  int checkCount = 0;
  int errorCount = 0;

  bit mActive = 0;
  int mK      = 0;
  int mLen    = 0;
  int mOp     = 0;
  bit mQ0     = 0;
  bit mExp    = 0;
  bit mErr    = 0;

  always #5 clk = ~clk;

  jk_driver #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .q_fb     (q_fb),
    .J        (J),
    .K        (K),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .err      (err),
    .exp_q    (exp_q)
  );

  // Flip-flop state after n clocks of op starting from q0.
  function automatic bit expAfter(input int op, input bit q0, input int n);
    if (n == 0) return q0;
    case (op)
      0:       return q0;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return q0 ^ n[0];
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelEdge();
    if (!rst_n) begin
      mActive = 0;
      mExp    = 0;
      mErr    = 0;
    end else if (!mActive) begin
      if (cmd_valid) begin
        mActive = 1;
        mK      = 1;
        mOp     = int'(cmd_op);
        mLen    = int'(cmd_len);
        mQ0     = q_fb;
        mErr    = 0;
      end
    end else if (mK == mLen + 2) begin
      mExp    = expAfter(mOp, mQ0, mLen + 1);
      mErr    = mErr | (q_fb != mExp);
      mActive = 0;
    end else begin
      mK++;
    end
  endtask

  task automatic checkAll();
    bit eDone;
    bit eExp;
    bit eJ;
    bit eK;
    eDone = mActive && (mK == mLen + 2);
    eExp  = mActive ? expAfter(mOp, mQ0, mK - 1) : mExp;
    eJ    = mActive && (mK <= mLen + 1) && mOp[1];
    eK    = mActive && (mK <= mLen + 1) && mOp[0];
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(!mActive && rst_n));
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("done", 32'(done), 32'(eDone));
    checkOutput("J", 32'(J), 32'(eJ));
    checkOutput("K", 32'(K), 32'(eK));
    checkOutput("exp_q", 32'(exp_q), 32'(eExp));
    checkOutput("mismatch", 32'(mismatch), 32'(eDone && (q_fb != eExp)));
    checkOutput("err", 32'(err), 32'(mErr));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] op,
                               input logic [LEN_W-1:0] len, input bit q);
    rst_n     = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
    q_fb      = q;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input bit q);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'b00, '0, q);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    q_fb      = 1'b0;

    applyStimulus(1'b0, 1'b1, 2'b11, 4'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'd3, 1'b0);
    idleCycles(1, 1'b0);

    // SET len=0 from q=0, then TOGGLE len=2 from q=1.
    applyStimulus(1'b1, 1'b1, 2'b10, 4'd0, 1'b0);
    idleCycles(4, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd2, 1'b1);
    idleCycles(6, 1'b0);

    // RESET len=1 with Q stuck at 1: err must stick until the next accept.
    applyStimulus(1'b1, 1'b1, 2'b01, 4'd1, 1'b1);
    idleCycles(8, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0, 1'b1);
    idleCycles(4, 1'b1);

    // cmd_valid held high while op and len keep changing.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)), LEN_W'($urandom_range(0, 3)), 1'b0);
    idleCycles(6, 1'b0);

    // Longest command: HOLD with the maximum length.
    applyStimulus(1'b1, 1'b1, 2'b00, 4'd15, 1'b1);
    idleCycles(20, 1'b1);

    // Reset for two cycles in the middle of a TOGGLE len=5.
    applyStimulus(1'b1, 1'b1, 2'b11, 4'd5, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, 1'b0);
    idleCycles(10, 1'b0);

    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), LEN_W'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/jk_driver.md
JK_DRIVER -- requirements
Module: jk_driver

Interface
REQ-001 SHALL have parameter LEN_W, default 4, giving the width of the cmd_len field.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 SHALL have port cmd_op, input, 2 bits: the op in {J,K} encoding (00 HOLD, 01 RESET, 10 SET, 11 TOGGLE).
REQ-007 SHALL have port cmd_len, input, LEN_W bits: the op is applied for cmd_len+1 cycles.
REQ-008 SHALL have port q_fb, input, 1 bit: Q fed back from the downstream JK flip-flop.
REQ-009 SHALL have ports J and K, output, 1 bit each: registered drive to the JK flip-flop.
REQ-010 SHALL have port busy, output, 1 bit: high in DRIVE or CHECK.
REQ-011 SHALL have port done, output, 1 bit: high for exactly the CHECK cycle.
REQ-012 SHALL have port mismatch, output, 1 bit: done & (q_fb != exp_q), combinational.
REQ-013 SHALL have port err, output, 1 bit: sticky error flag.
REQ-014 SHALL have port exp_q, output, 1 bit: the modelled expected flip-flop state.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE and CHECK.
REQ-016 SHALL drive cmd_ready = (state==IDLE) & rst_n; a command is accepted on a clock edge with cmd_valid & cmd_ready.
REQ-017 SHALL, on accept: latch op, load the counter with cmd_len, load exp_q from q_fb, clear err, set {J,K}=op, and go to DRIVE.
REQ-018 SHALL hold {J,K}=op for exactly cmd_len+1 consecutive cycles while in DRIVE.
REQ-019 SHALL, on each DRIVE edge, update exp_q per op: HOLD unchanged, RESET 0, SET 1, TOGGLE ~exp_q.
REQ-020 SHALL decrement the counter in DRIVE; on the edge where the counter is 0, set {J,K}=00 and go to CHECK.
REQ-021 SHALL spend exactly one cycle in CHECK, with done=1 and mismatch evaluated; err is set at the CHECK exit edge if mismatch, then the FSM returns to IDLE.
REQ-022 SHALL give a latency of cmd_len+2 cycles after the accept edge to the done cycle; the next accept occurs no earlier than the edge ending the first IDLE cycle after CHECK.
REQ-023 SHALL ignore cmd_valid while busy, with no queuing and no change to the latched op or len.
REQ-024 SHALL drive {J,K}=00 in IDLE and CHECK.
REQ-025 SHALL count the maximum cmd_len (2^LEN_W-1) correctly, giving 2^LEN_W DRIVE cycles with no wrap error.
REQ-026 SHALL hold err until reset or the next accept; done=0 clears nothing.

Reset
REQ-027 SHALL, at an edge with rst_n=0: state=IDLE, J=K=0, counter=0, exp_q=0, err=0; consequently busy=done=mismatch=0.
REQ-028 SHALL abort DRIVE or CHECK immediately on reset mid-operation, with no done pulse and no err update for the aborted command.
REQ-029 SHALL hold cmd_ready=0 while rst_n=0; cmd_valid is ignored.

Verification
REQ-030 SHALL cover: reset asserted for 2 cycles mid-DRIVE of TOGGLE len=5 -> J=K=0, busy=0, done never pulses; cmd_ready=1 in the first cycle after release.
REQ-031 SHALL cover: q_fb=1, TOGGLE len=2 -> J=K=1 for 3 cycles; done in cycle 4 after accept; exp_q=0, mismatch=0, err=0.
REQ-032 SHALL cover: q_fb=0, SET len=0 -> J=1,K=0 for 1 cycle; done in cycle 2; exp_q=1, err=0.
REQ-033 SHALL cover: q_fb forced to 1, RESET len=1 -> mismatch=1 in the CHECK cycle; err=1 from the next cycle until the next accept, which clears it.
REQ-034 SHALL cover: cmd_valid held high with op changing during busy -> changes are ignored; the second command is accepted only from IDLE after done.
REQ-035 SHALL cover: HOLD len=15 (LEN_W=4) -> 16 DRIVE cycles with J=K=0; done in cycle 17; exp_q equals the initial q_fb.
